uart_cmd_wrapper: RTL and testbench

//  Command/response layer above the UART byte interface.
//  - RX path: takes received bytes (rx_byte/rx_rdy) and acknowledges each with clr_rx_rdy.

---
 rtl/uart_cmd_wrapper.sv | 135 +++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// Command/response layer over a UART byte interface: packs received bytes
// MSB-first into command words and sends single-byte responses.
module uart_cmd_wrapper #(
  parameter int CMD_BYTES   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   send_resp,
  input  logic [7:0]             resp,
  output logic [7:0]             tx_byte,
  output logic                   trmt,
  input  logic                   tx_done,
  output logic                   resp_busy,
  output logic                   resp_sent
);

  localparam int W  = 8 * CMD_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [2:0]    C_LAST = 3'(CMD_BYTES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_WAIT} tx_state_t;

  logic [2:0]    count;
  logic [W-1:0]  stage;
  logic [W-1:0]  shifted;
  logic [TW-1:0] tcnt;
  logic          capture;
  logic          complete;
  logic          timeout;

  tx_state_t state, state_nxt;
  logic      trmt_nxt;
  logic      busy_nxt;
  logic      sent_nxt;
  logic      load_resp;

  // The acknowledge cycle masks rx_rdy so a late-falling UART flag is not re-captured.
  assign capture  = rx_rdy & ~clr_rx_rdy;
  assign complete = capture && (count == C_LAST);
  assign timeout  = !capture && (count != 3'd0) && (tcnt == T_LAST);
  assign shifted  = W'({stage, rx_byte});

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rx_rdy <= 1'b0;
      count      <= 3'd0;
      stage      <= '0;
      tcnt       <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      clr_rx_rdy <= capture;

      if (complete) begin
        cmd   <= shifted;
        stage <= '0;
        count <= 3'd0;
      end else if (capture) begin
        stage <= shifted;
        count <= count + 3'd1;
      end else if (timeout) begin
        stage <= '0;
        count <= 3'd0;
      end

      // Completion outranks both the consumer acknowledge and a new first byte.
      if (complete)
        cmd_rdy <= 1'b1;
      else if ((capture && count == 3'd0) || clr_cmd_rdy)
        cmd_rdy <= 1'b0;

      if (capture || timeout || count == 3'd0)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      tx_byte   <= 8'h00;
      trmt      <= 1'b0;
      resp_busy <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      state     <= state_nxt;
      trmt      <= trmt_nxt;
      resp_busy <= busy_nxt;
      resp_sent <= sent_nxt;
      if (load_resp)
        tx_byte <= resp;
    end
  end

  // TX_ARM exists to skip a tx_done left over from the previous byte.
  always_comb begin
    state_nxt = state;
    trmt_nxt  = 1'b0;
    busy_nxt  = resp_busy;
    sent_nxt  = 1'b0;
    load_resp = 1'b0;
    case (state)
      TX_IDLE: begin
        if (send_resp) begin
          load_resp = 1'b1;
          trmt_nxt  = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = TX_ARM;
        end
      end
      TX_ARM: state_nxt = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          sent_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = TX_IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = TX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: per-cycle vector table plus hand
// sequences for slow flags, timeout boundaries and mid-operation reset.
module tb_uart_cmd_wrapper;

  localparam int TIMEOUT_CYC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic [7:0]  tx_byte;
  logic        trmt;
  logic        tx_done;
  logic        resp_busy;
  logic        resp_sent;

  int errors = 0;
  int checks = 0;
  int clr_pulses = 0;

  typedef struct packed {
    logic       rx_rdy;
    logic [7:0] rx_byte;
    logic       clr_cmd_rdy;
    logic       send_resp;
    logic [7:0] resp;
    logic       tx_done;
  } in_t;

  typedef struct packed {
    logic        clr;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        trmt;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        sent;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  vec_t vecs[$];

  uart_cmd_wrapper #(.CMD_BYTES(2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_rdy(rx_rdy),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .tx_byte(tx_byte), .trmt(trmt), .tx_done(tx_done),
    .resp_busy(resp_busy), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (clr_rx_rdy) clr_pulses++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t mk_in(input logic r, input logic [7:0] b, input logic cc,
                                input logic s, input logic [7:0] rp, input logic td);
    mk_in = '{rx_rdy: r, rx_byte: b, clr_cmd_rdy: cc, send_resp: s, resp: rp, tx_done: td};
  endfunction

  function automatic out_t mk_out(input logic c, input logic [15:0] cm, input logic cr,
                                  input logic t, input logic [7:0] tb, input logic bz,
                                  input logic st);
    mk_out = '{clr: c, cmd: cm, cmd_rdy: cr, trmt: t, tx_byte: tb, busy: bz, sent: st};
  endfunction

  function automatic out_t sample_outputs();
    sample_outputs = mk_out(clr_rx_rdy, cmd, cmd_rdy, trmt, tx_byte, resp_busy, resp_sent);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input in_t s);
    rx_rdy      = s.rx_rdy;
    rx_byte     = s.rx_byte;
    clr_cmd_rdy = s.clr_cmd_rdy;
    send_resp   = s.send_resp;
    resp        = s.resp;
    tx_done     = s.tx_done;
  endtask

  task automatic check_output(input string name, input out_t exp);
    out_t act;
    act = sample_outputs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got clr=%b cmd=%h rdy=%b trmt=%b tx=%h busy=%b sent=%b, expected clr=%b cmd=%h rdy=%b trmt=%b tx=%h busy=%b sent=%b",
               name, act.clr, act.cmd, act.cmd_rdy, act.trmt, act.tx_byte, act.busy, act.sent,
               exp.clr, exp.cmd, exp.cmd_rdy, exp.trmt, exp.tx_byte, exp.busy, exp.sent);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    tick();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    int bad;
    out_t zeros;
    zeros = '0;

    apply_stimulus('0);
    rst = 1'b1;
    tick();
    check_output("reset", zeros);
    tick();
    rst = 1'b0;

    // Per-cycle vectors: inputs held for one clock, outputs checked just after the edge.
    vecs.push_back('{mk_in(1, 8'hA5, 0, 0, 8'h00, 0), mk_out(1, 16'h0000, 0, 0, 8'h00, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'h0000, 0, 0, 8'h00, 0, 0)});
    vecs.push_back('{mk_in(1, 8'h3C, 0, 0, 8'h00, 0), mk_out(1, 16'hA53C, 1, 0, 8'h00, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'hA53C, 1, 0, 8'h00, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 1, 8'h5F, 0), mk_out(0, 16'hA53C, 1, 1, 8'h5F, 1, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 1, 8'h77, 1), mk_out(0, 16'hA53C, 1, 0, 8'h5F, 1, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 1, 8'h77, 0), mk_out(0, 16'hA53C, 1, 0, 8'h5F, 1, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 1), mk_out(0, 16'hA53C, 1, 0, 8'h5F, 0, 1)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'hA53C, 1, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(1, 8'hBE, 0, 0, 8'h00, 0), mk_out(1, 16'hA53C, 0, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'hA53C, 0, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(1, 8'hEF, 1, 0, 8'h00, 0), mk_out(1, 16'hBEEF, 1, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'hBEEF, 1, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(1, 8'h12, 0, 0, 8'h00, 0), mk_out(1, 16'hBEEF, 0, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'hBEEF, 0, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(1, 8'h34, 0, 0, 8'h00, 0), mk_out(1, 16'h1234, 1, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 1, 0, 8'h00, 0), mk_out(0, 16'h1234, 0, 0, 8'h5F, 0, 0)});
    vecs.push_back('{mk_in(1, 8'h56, 0, 1, 8'hA0, 0), mk_out(1, 16'h1234, 0, 1, 8'hA0, 1, 0)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'h1234, 0, 0, 8'hA0, 1, 0)});
    vecs.push_back('{mk_in(1, 8'h78, 0, 0, 8'h00, 1), mk_out(1, 16'h5678, 1, 0, 8'hA0, 0, 1)});
    vecs.push_back('{mk_in(0, 8'h00, 0, 0, 8'h00, 0), mk_out(0, 16'h5678, 1, 0, 8'hA0, 0, 0)});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].stim);
      tick();
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end
    apply_stimulus('0);

    // Slow UART flag: rx_rdy stays high through the acknowledge cycle.
    base = clr_pulses;
    rx_byte = 8'h9A; rx_rdy = 1'b1;
    tick(); tick();
    rx_rdy = 1'b0;
    tick();
    rx_byte = 8'hBC; rx_rdy = 1'b1;
    tick(); tick();
    rx_rdy = 1'b0;
    tick();
    check_val("slow_flag_cmd", {16'h0, cmd}, 32'h9ABC);
    check_val("slow_flag_rdy", {31'h0, cmd_rdy}, 32'h1);
    check_val("slow_flag_pulses", clr_pulses - base, 32'd2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    check_val("after_slow_cmd", {16'h0, cmd}, 32'hC3D4);

    // Partial command abandoned long enough to time out.
    send_byte(8'h11);
    bad = 0;
    for (int i = 0; i < TIMEOUT_CYC + 10; i++) begin
      tick();
      if (cmd !== 16'hC3D4 || cmd_rdy !== 1'b0) bad++;
    end
    check_val("timeout_wait_stable", bad, 32'd0);
    send_byte(8'h22);
    check_val("timeout_first_byte_cmd", {16'h0, cmd}, 32'hC3D4);
    send_byte(8'h33);
    check_val("timeout_new_cmd", {16'h0, cmd}, 32'h2233);

    // Second byte captured on the very cycle the timeout would fire.
    send_byte(8'h44);
    idle_ticks(TIMEOUT_CYC - 2);
    rx_byte = 8'h55; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    check_val("timeout_edge_capture", {16'h0, cmd}, 32'h4455);
    tick();

    // One cycle later the partial byte is discarded.
    send_byte(8'h66);
    idle_ticks(TIMEOUT_CYC - 1);
    send_byte(8'h77);
    check_val("timeout_edge_discard_hold", {16'h0, cmd}, 32'h4455);
    send_byte(8'h88);
    check_val("timeout_edge_discard_cmd", {16'h0, cmd}, 32'h7788);

    // Reset with a partial command staged and the TX FSM waiting for tx_done.
    send_resp = 1'b1; resp = 8'h99;
    tick();
    send_resp = 1'b0;
    tick();
    rx_byte = 8'hEE; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; rst = 1'b1;
    tick();
    check_output("reset_mid_op", zeros);
    rst = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_output("reset_no_resp_sent", zeros);
    send_byte(8'h01);
    send_byte(8'h02);
    check_val("after_reset_cmd", {16'h0, cmd}, 32'h0102);
    check_val("after_reset_rdy", {31'h0, cmd_rdy}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
